dram_access_arbiter: RTL and testbench
======================================

// Module: dram_access_arbiter
// PURPOSE
//  Sequences and shares the single-port DRAM between two requesters: instruction fetch (If, read-only)
//  and data memory (Mem, read/write). Sits between the CPU pipeline front/back ends and DRAM.
//  Converts request/done handshakes into timed DRAM RD/WR strobes; returns read data per port.
//  Mem has priority; a starvation counter guarantees If progress.
// PARAMETERS
//  ADDR_W      16  address width
//  DATA_W      16  data width
//  MEM_LAT     2   cycles RD/WR held before DramDataOut is valid / write is committed (>=1)
//  STARVE_MAX  4   consecutive If losses after which If wins the next arbitration (>=1)
// PORTS
//  Clk          in   1       single clock, all state on rising edge
//  Reset        in   1       asynchronous, active-high
//  IfReq        in   1       fetch request; level, held until IfDone
//  IfAddr       in   ADDR_W  fetch address; stable while IfReq high
//  IfData       out  DATA_W  fetch read data; valid with IfDone, held until next If read
//  IfDone       out  1       one-cycle completion pulse to If
//  MemReq       in   1       data request; level, held until MemDone
//  MemWE        in   1       1 = write, 0 = read; stable while MemReq high
//  MemAddr      in   ADDR_W  data address
//  MemWData     in   DATA_W  write data
//  MemRData     out  DATA_W  data read result; valid with MemDone, held until next Mem read
//  MemDone      out  1       one-cycle completion pulse to Mem
//  DramAddr     out  ADDR_W  to DRAM Addr
//  DramDataIn   out  DATA_W  to DRAM DataIn
//  DramRD       out  1       to DRAM RD
//  DramWR       out  1       to DRAM WR
//  DramDataOut  in   DATA_W  from DRAM DataOut
//  Busy         out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (IfData, MemRData, Dram* cleared); starve count 0; latency count 0.
//  Reset mid-access: DramRD/DramWR drop immediately (async); no Done pulse; access is abandoned.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: sample IfReq/MemReq at edge. Neither -> stay. Only one -> grant it. Both -> Mem, unless
//    starve==STARVE_MAX -> If. Grant registers port id, address, write data, WE (If: WE=0).
//   ACCESS: DramAddr/DramDataIn from grant registers; exactly one of DramRD/DramWR high for MEM_LAT
//    cycles (counter MEM_LAT-1 down to 0); inputs are not re-sampled.
//   DONE: strobes low; on read, DramDataOut is captured into granted port's data register
//    (sampled at the ACCESS->DONE edge); granted port's Done high this cycle only; then IDLE.
//  Latency: request seen at IDLE edge n -> strobes cycles n+1..n+MEM_LAT -> Done in cycle n+MEM_LAT+1.
//   Throughput: one access per MEM_LAT+2 cycles (one IDLE cycle between accesses).
//  Starvation: starve increments (saturating at STARVE_MAX) when If requests and Mem is granted;
//   clears when If is granted. Never wraps.
//  DramRD and DramWR never high together; Dram* outputs only change at FSM transitions.
//  Req dropped during ACCESS: access completes, Done still pulses. Req still high in cycle after Done
//   is treated as a new request (back-to-back allowed).
//  IfDone and MemDone never high in same cycle. Non-granted port's data register unchanged.
//  Writes leave MemRData/IfData unchanged.
// STRUCTURE
//  Package dram_ctrl_pkg: state enum {IDLE, ACCESS, DONE}, port-select enum {PORT_IF, PORT_MEM},
//   default widths and MEM_LAT.
//  Sub-module dram_arb_prio: fixed-priority pick plus saturating starvation counter;
//   inputs IfReq, MemReq, arbitrate-enable; output grant select.
//  Top: FSM, latency counter, grant/operand registers, per-port read-data registers.
// TESTING
//  1 Reset, then MemReq WE=1 Addr=16'h5555 WData=16'hF00D -> DramWR high exactly MEM_LAT cycles
//    with DramAddr=5555/DramDataIn=F00D; MemDone one pulse at cycle n+MEM_LAT+1.
//  2 MemReq WE=0 Addr=16'h5555 after test 1 -> DramRD for MEM_LAT cycles; MemRData=F00D with MemDone;
//    IfData still 0.
//  3 IfReq and MemReq held high continuously -> grants Mem x STARVE_MAX then If, repeating;
//    no IfDone/MemDone overlap; DramRD/DramWR never both high.
//  4 Reset asserted mid-ACCESS -> DramRD/DramWR 0 without clock edge; no Done; Busy 0; next request
//    completes normally.
//  5 IfReq dropped during ACCESS -> IfDone still pulses with read data; no second access issued.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared types and defaults for the DRAM access arbiter.
package dram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_t;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dram_arb_prio.sv
// Fixed-priority pick (Mem over If) with a saturating starvation counter
// that hands the grant to If once it has lost STARVE_MAX times in a row.
module dram_arb_prio
    import dram_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_if_req,
    input  logic  i_mem_req,
    input  logic  i_arb_en,
    output port_t o_grant
);

    localparam int SW = cnt_width(STARVE_MAX);

    logic [SW-1:0] r_starve;
    logic          w_starved;

    assign w_starved = (r_starve == SW'(STARVE_MAX));

    // Grant selection: Mem wins unless it is absent or If has been starved.
    always_comb begin
        o_grant = PORT_MEM;
        if (i_if_req && (!i_mem_req || w_starved)) begin
            o_grant = PORT_IF;
        end
    end

    // Starvation counter: counts If losses, saturates, clears on an If grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve <= '0;
        end else if (i_arb_en) begin
            if (o_grant == PORT_IF) begin
                r_starve <= '0;
            end else if (i_if_req && !w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_access_arbiter.sv
// Shares one single-port DRAM between instruction fetch (read-only) and
// data memory (read/write). Each access is IDLE -> ACCESS (strobe held
// MEM_LAT cycles) -> DONE (one-cycle Done pulse, read data captured).
module dram_access_arbiter
    import dram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic [DATA_W-1:0] IfData,
    output logic              IfDone,
    input  logic              MemReq,
    input  logic              MemWE,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemWData,
    output logic [DATA_W-1:0] MemRData,
    output logic              MemDone,
    output logic [ADDR_W-1:0] DramAddr,
    output logic [DATA_W-1:0] DramDataIn,
    output logic              DramRD,
    output logic              DramWR,
    input  logic [DATA_W-1:0] DramDataOut,
    output logic              Busy
);

    localparam int LW = cnt_width(MEM_LAT);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_arb_en;
    logic              w_acc_end;
    port_t             w_grant;
    logic              w_grant_we;

    port_t             r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [LW-1:0]     r_lat;
    logic              r_rd;
    logic              r_wr;
    logic              r_if_done;
    logic              r_mem_done;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_data;

    dram_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .i_clk     (Clk),
        .i_rst     (Reset),
        .i_if_req  (IfReq),
        .i_mem_req (MemReq),
        .i_arb_en  (w_arb_en),
        .o_grant   (w_grant)
    );

    // Only Mem can write; an If grant is always a read.
    assign w_grant_we = (w_grant == PORT_MEM) && MemWE;

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: arbitrate in IDLE, wait out the latency in ACCESS.
    always_comb begin
        w_next_state = r_state;
        w_arb_en     = 1'b0;
        w_acc_end    = 1'b0;
        case (r_state)
            IDLE: begin
                if (IfReq || MemReq) begin
                    w_arb_en     = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (r_lat == '0) begin
                    w_acc_end    = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Grant registers: latched once per arbitration, inputs ignored afterwards.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_port  <= PORT_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_arb_en) begin
            r_port  <= w_grant;
            r_we    <= w_grant_we;
            r_addr  <= (w_grant == PORT_MEM) ? MemAddr : IfAddr;
            r_wdata <= (w_grant == PORT_MEM) ? MemWData : '0;
        end
    end

    // Latency counter: loads MEM_LAT-1 on grant, counts down to 0 in ACCESS.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lat <= '0;
        end else if (w_arb_en) begin
            r_lat <= LW'(MEM_LAT - 1);
        end else if ((r_state == ACCESS) && (r_lat != '0)) begin
            r_lat <= r_lat - 1'b1;
        end
    end

    // DRAM strobes: exactly one raised on entry to ACCESS, dropped on exit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
        end else if (w_arb_en) begin
            r_rd <= !w_grant_we;
            r_wr <= w_grant_we;
        end else if (w_acc_end) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
        end
    end

    // Completion: one-cycle Done to the granted port, read data captured at ACCESS exit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_if_data  <= '0;
            r_mem_data <= '0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            if (w_acc_end) begin
                if (r_port == PORT_IF) begin
                    r_if_done <= 1'b1;
                    if (!r_we) begin
                        r_if_data <= DramDataOut;
                    end
                end else begin
                    r_mem_done <= 1'b1;
                    if (!r_we) begin
                        r_mem_data <= DramDataOut;
                    end
                end
            end
        end
    end

    assign DramAddr   = r_addr;
    assign DramDataIn = r_wdata;
    assign DramRD     = r_rd;
    assign DramWR     = r_wr;
    assign IfDone     = r_if_done;
    assign MemDone    = r_mem_done;
    assign IfData     = r_if_data;
    assign MemRData   = r_mem_data;
    assign Busy       = (r_state != IDLE);

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Directed bench for dram_access_arbiter: vector table of single accesses
// against a small DRAM model, plus sequences for contention, reset and
// dropped requests.
module tb_dram_access_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_data;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic [15:0] dram_addr;
    logic [15:0] dram_din;
    logic        dram_rd;
    logic        dram_wr;
    logic [15:0] dram_dout = '0;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    dram_access_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .IfReq       (if_req),
        .IfAddr      (if_addr),
        .IfData      (if_data),
        .IfDone      (if_done),
        .MemReq      (mem_req),
        .MemWE       (mem_we),
        .MemAddr     (mem_addr),
        .MemWData    (mem_wdata),
        .MemRData    (mem_rdata),
        .MemDone     (mem_done),
        .DramAddr    (dram_addr),
        .DramDataIn  (dram_din),
        .DramRD      (dram_rd),
        .DramWR      (dram_wr),
        .DramDataOut (dram_dout),
        .Busy        (busy)
    );

    always #5 clk = ~clk;

    // DRAM model: writes land on rising edges while WR is high; reads
    // present the addressed word, unwritten locations read as zero.
    logic [15:0] dram_mem [logic [15:0]];
    always @(posedge clk) begin
        if (dram_wr) dram_mem[dram_addr] = dram_din;
    end
    always @(negedge clk) begin
        dram_dout = dram_mem.exists(dram_addr) ? dram_mem[dram_addr] : 16'h0000;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete access from the IDLE cycle; returns in the following IDLE cycle.
    task automatic do_txn(input string tag, input bit is_mem, input bit we,
                          input logic [15:0] addr, input logic [15:0] wdata);
        bit eff_we;
        logic [15:0] exp_din;
        eff_we  = is_mem && we;
        exp_din = is_mem ? wdata : 16'h0000;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(negedge clk);
        for (int c = 0; c < MEM_LAT; c++) begin
            chk($sformatf("%s_strobe%0d", tag, c),
                64'({busy, dram_rd, dram_wr, if_done, mem_done, dram_addr, dram_din}),
                64'({1'b1, !eff_we, eff_we, 1'b0, 1'b0, addr, exp_din}));
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'({busy, dram_rd, dram_wr, if_done, mem_done}),
            64'({1'b1, 1'b0, 1'b0, !is_mem, is_mem}));
        if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, 64'({busy, dram_rd, dram_wr, if_done, mem_done}), 64'(0));
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_if;
        logic [15:0] exp_mem;
    } vec_t;

    vec_t vecs [9];
    bit   seq_mem [10];

    initial begin
        int  ev;
        bit  overlap, both_strobes, extra;

        vecs[0] = '{1'b1, 1'b1, 16'h5555, 16'hF00D, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h5555, 16'h0000, 16'h0000, 16'hF00D};
        vecs[2] = '{1'b0, 1'b0, 16'h5555, 16'h0000, 16'hF00D, 16'hF00D};
        vecs[3] = '{1'b1, 1'b1, 16'h1234, 16'hA5A5, 16'hF00D, 16'hF00D};
        vecs[4] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hA5A5, 16'hF00D};
        vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 16'hC3C3, 16'hA5A5, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hC3C3, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hC3C3, 16'hA5A5};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            64'({if_data, mem_rdata, dram_addr, dram_din, dram_rd, dram_wr, if_done, mem_done, busy}),
            64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 64'({busy, dram_rd, dram_wr, if_done, mem_done}), 64'(0));

        // Single accesses from the table
        for (int i = 0; i < 9; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_ifdata", i), 64'(if_data), 64'(vecs[i].exp_if));
            chk($sformatf("vec%0d_memrdata", i), 64'(mem_rdata), 64'(vecs[i].exp_mem));
        end

        // Both requesters held: Mem x STARVE_MAX, then If, repeating
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h5555;
        if_req = 1'b1; if_addr = 16'h1234;
        ev = 0; overlap = 1'b0; both_strobes = 1'b0;
        for (int c = 0; c < 60 && ev < 10; c++) begin
            @(negedge clk);
            if (dram_rd && dram_wr) both_strobes = 1'b1;
            if (if_done && mem_done) overlap = 1'b1;
            if (if_done || mem_done) begin
                seq_mem[ev] = mem_done;
                ev++;
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("contend_events", 64'(ev), 64'(10));
        chk("contend_done_overlap", 64'(overlap), 64'(0));
        chk("contend_strobe_overlap", 64'(both_strobes), 64'(0));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("contend_grant%0d_is_mem", i), 64'(seq_mem[i]),
                64'(((i % (STARVE_MAX + 1)) == STARVE_MAX) ? 1'b0 : 1'b1));
        end
        chk("contend_memrdata", 64'(mem_rdata), 64'(16'hF00D));
        chk("contend_ifdata", 64'(if_data), 64'(16'hA5A5));

        // Reset in the middle of an access
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h5555;
        @(negedge clk);
        chk("midreset_pre_strobe", 64'({busy, dram_rd}), 64'(2'b11));
        #2 rst = 1'b1;
        #1;
        chk("midreset_async", 64'({busy, dram_rd, dram_wr, if_done, mem_done, mem_rdata, if_data}), 64'(0));
        mem_req = 1'b0;
        @(negedge clk);
        chk("midreset_no_done", 64'({busy, dram_rd, dram_wr, if_done, mem_done}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        do_txn("after_reset", 1'b1, 1'b0, 16'h5555, 16'h0000);
        chk("after_reset_memrdata", 64'(mem_rdata), 64'(16'hF00D));
        chk("after_reset_ifdata", 64'(if_data), 64'(16'h0000));

        // If request dropped during ACCESS
        if_req = 1'b1; if_addr = 16'h1234;
        @(negedge clk);
        if_req = 1'b0;
        chk("drop_strobe", 64'({busy, dram_rd, dram_wr, dram_addr}), 64'({3'b110, 16'h1234}));
        repeat (MEM_LAT - 1) @(negedge clk);
        @(negedge clk);
        chk("drop_done", 64'({if_done, mem_done, if_data}), 64'({2'b10, 16'hA5A5}));
        extra = 1'b0;
        for (int c = 0; c < 2 * (MEM_LAT + 2); c++) begin
            @(negedge clk);
            if (dram_rd || dram_wr || if_done || mem_done || busy) extra = 1'b1;
        end
        chk("drop_no_second_access", 64'(extra), 64'(0));
        chk("drop_memrdata_kept", 64'(mem_rdata), 64'(16'hF00D));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
